// File: rtl/conv3x3_engine.sv
// Raster-scan 3x3 neighbourhood filter. It reads a synchronous source RAM, reuses
// window columns across interior pixels, and writes one filtered pixel per site.
module conv3x3_engine #(
  parameter int unsigned IMG_W = 100,
  parameter int unsigned IMG_H = 100,
  parameter int unsigned DW    = 8,
  parameter int unsigned AW    = 14
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic [1:0]    mode_i,
  input  logic          edge_mode_i,
  output logic [AW-1:0] rd_addr_o,
  input  logic [DW-1:0] rd_data_i,
  output logic          wr_en_o,
  output logic [AW-1:0] wr_addr_o,
  output logic [DW-1:0] wr_data_o,
  output logic          busy_o,
  output logic          done_o
);

  localparam int unsigned CW      = $clog2(IMG_W);
  localparam int unsigned RW      = $clog2(IMG_H);
  localparam int unsigned SW2     = DW + 4;
  localparam int unsigned SW3     = DW + 5;
  localparam int unsigned PIX_MAX = (1 << DW) - 1;

  typedef enum logic [2:0] {
    S_IDLE, S_EDGE_RD, S_EDGE_CAP, S_FILL, S_SLIDE, S_WRITE, S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [RW-1:0]          row_q, row_d;
  logic [CW-1:0]          col_q, col_d;
  logic [AW-1:0]          pix_q, pix_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [8:0][DW-1:0]     win_q, win_d;
  logic [1:0]             mode_q, mode_d;
  logic                   edge_q, edge_d;
  logic [AW-1:0]          rd_addr_q, rd_addr_d;
  logic                   wr_en_q, wr_en_d;
  logic [AW-1:0]          wr_addr_q, wr_addr_d;
  logic [DW-1:0]          wr_data_q, wr_data_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [DW-1:0]          kres;

  // Address of window tap j (row-major 0..8) around centre address p.
  function automatic logic [AW-1:0] tap_addr(input logic [AW-1:0] p, input logic [3:0] j);
    logic [AW-1:0] rofs;
    logic [AW-1:0] cofs;
    case (j)
      4'd0, 4'd1, 4'd2: rofs = '0;
      4'd3, 4'd4, 4'd5: rofs = AW'(IMG_W);
      default:          rofs = AW'(2 * IMG_W);
    endcase
    case (j)
      4'd0, 4'd3, 4'd6: cofs = '0;
      4'd1, 4'd4, 4'd7: cofs = AW'(1);
      default:          cofs = AW'(2);
    endcase
    return p - AW'(IMG_W) - AW'(1) + rofs + cofs;
  endfunction

  // Window update: FILL captures taps in order, SLIDE shifts then refills the right column.
  always_comb begin
    win_d = win_q;
    case (state_q)
      S_FILL: begin
        if (cnt_q != 4'd0) win_d[4'(cnt_q - 4'd1)] = rd_data_i;
      end
      S_SLIDE: begin
        case (cnt_q)
          4'd0: begin
            for (int r = 0; r < 3; r++) begin
              win_d[3*r]   = win_q[3*r+1];
              win_d[3*r+1] = win_q[3*r+2];
            end
          end
          4'd1:    win_d[2] = rd_data_i;
          4'd2:    win_d[5] = rd_data_i;
          default: win_d[8] = rd_data_i;
        endcase
      end
      default: ;
    endcase
  end

  // Kernel evaluated on the next window so the result is ready as WRITE is entered.
  always_comb begin
    logic [SW2-1:0] gsum, c5, n4, d2;
    logic [SW3-1:0] c8, n8, d3, mag;
    logic [DW-1:0]  gauss, sharp, lap;
    gsum = SW2'(win_d[0]) + (SW2'(win_d[1]) << 1) + SW2'(win_d[2])
         + (SW2'(win_d[3]) << 1) + (SW2'(win_d[4]) << 2) + (SW2'(win_d[5]) << 1)
         + SW2'(win_d[6]) + (SW2'(win_d[7]) << 1) + SW2'(win_d[8]);
    gauss = DW'(gsum >> 4);
    c5 = (SW2'(win_d[4]) << 2) + SW2'(win_d[4]);
    n4 = SW2'(win_d[1]) + SW2'(win_d[3]) + SW2'(win_d[5]) + SW2'(win_d[7]);
    d2 = c5 - n4;
    if (d2[SW2-1])                   sharp = '0;
    else if (d2 > SW2'(PIX_MAX))     sharp = '1;
    else                             sharp = DW'(d2);
    c8 = SW3'(win_d[4]) << 3;
    n8 = SW3'(win_d[0]) + SW3'(win_d[1]) + SW3'(win_d[2]) + SW3'(win_d[3])
       + SW3'(win_d[5]) + SW3'(win_d[6]) + SW3'(win_d[7]) + SW3'(win_d[8]);
    d3  = c8 - n8;
    mag = d3[SW3-1] ? (SW3'(0) - d3) : d3;
    lap = (mag > SW3'(PIX_MAX)) ? '1 : DW'(mag);
    case (mode_q)
      2'd0:    kres = win_d[4];
      2'd1:    kres = gauss;
      2'd2:    kres = sharp;
      default: kres = lap;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    logic          col_last, row_last, nxt_border;
    logic [CW-1:0] col_n;
    logic [RW-1:0] row_n;
    logic [AW-1:0] pix_n;
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    pix_d     = pix_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    edge_d    = edge_q;
    rd_addr_d = rd_addr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    col_last   = (col_q == CW'(IMG_W - 1));
    row_last   = (row_q == RW'(IMG_H - 1));
    col_n      = col_last ? '0 : col_q + CW'(1);
    row_n      = col_last ? row_q + RW'(1) : row_q;
    pix_n      = pix_q + AW'(1);
    nxt_border = (row_n == '0) || (row_n == RW'(IMG_H - 1)) ||
                 (col_n == '0) || (col_n == CW'(IMG_W - 1));

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mode_d    = mode_i;
          edge_d    = edge_mode_i;
          row_d     = '0;
          col_d     = '0;
          pix_d     = '0;
          rd_addr_d = '0;
          busy_d    = 1'b1;
          state_d   = S_EDGE_RD;
        end
      end
      S_EDGE_RD: state_d = S_EDGE_CAP;
      S_EDGE_CAP: begin
        wr_en_d   = 1'b1;
        wr_addr_d = pix_q;
        wr_data_d = edge_q ? '0 : rd_data_i;
        state_d   = S_WRITE;
      end
      S_FILL: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q < 4'd8) rd_addr_d = tap_addr(pix_q, cnt_q + 4'd1);
        if (cnt_q == 4'd9) begin
          cnt_d     = '0;
          wr_en_d   = 1'b1;
          wr_addr_d = pix_q;
          wr_data_d = kres;
          state_d   = S_WRITE;
        end
      end
      S_SLIDE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd0) rd_addr_d = tap_addr(pix_q, 4'd5);
        if (cnt_q == 4'd1) rd_addr_d = tap_addr(pix_q, 4'd8);
        if (cnt_q == 4'd3) begin
          cnt_d     = '0;
          wr_en_d   = 1'b1;
          wr_addr_d = pix_q;
          wr_data_d = kres;
          state_d   = S_WRITE;
        end
      end
      S_WRITE: begin
        if (row_last && col_last) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          row_d = row_n;
          col_d = col_n;
          pix_d = pix_n;
          cnt_d = '0;
          if (nxt_border) begin
            rd_addr_d = pix_n;
            state_d   = S_EDGE_RD;
          end else if (col_n == CW'(1)) begin
            rd_addr_d = tap_addr(pix_n, 4'd0);
            state_d   = S_FILL;
          end else begin
            rd_addr_d = tap_addr(pix_n, 4'd2);
            state_d   = S_SLIDE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      pix_q     <= '0;
      cnt_q     <= '0;
      win_q     <= '0;
      mode_q    <= '0;
      edge_q    <= 1'b0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      pix_q     <= pix_d;
      cnt_q     <= cnt_d;
      win_q     <= win_d;
      mode_q    <= mode_d;
      edge_q    <= edge_d;
      rd_addr_q <= rd_addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign rd_addr_o = rd_addr_q;
  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule
